// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding, opcodes and widths for the accumulator CPU
package cpu_pkg;

  localparam int PC_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } seq_state_t;

  localparam logic [2:0] OP_ACM  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_BNZ  = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_LW   = 3'b111;

  // Opcodes whose EXEC cycle drives the accumulator onto the memory address
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with branch load, increment and synchronous reset
module pc_reg
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Reset wins, then a taken branch, then the natural wrap-around increment
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/exec sequencer; optional FETCH_SINGLE_STEP_EN adds a step input
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [7:0]      mem_rdata,
  input  logic            brnch,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic [2:0]      opcode,
  output logic [4:0]      imm,
  output logic            sel_mem_in,
  output logic            exec_en,
  output logic            wb_en,
  output logic [1:0]      state
);

  seq_state_t cur_state;
  seq_state_t nxt_state;
  logic [7:0] ir_q;
  logic       fetch_go;
  logic       pc_load;
  logic       pc_inc;

`ifdef FETCH_SINGLE_STEP_EN
  assign fetch_go = run & step;
`else
  assign fetch_go = run;
`endif

  assign ir     = ir_q;
  assign opcode = ir_q[7:5];
  assign imm    = ir_q[4:0];
  assign state  = cur_state;

  // State register; reset always returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Instruction register captures the synchronous read issued during FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= 8'h00;
    end else if (cur_state == LATCH) begin
      ir_q <= mem_rdata;
    end
  end

  // Next state, memory mux select, write qualifiers and PC control
  always_comb begin
    nxt_state  = cur_state;
    sel_mem_in = 1'b0;
    exec_en    = 1'b0;
    wb_en      = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (cur_state)
      FETCH: begin
        if (fetch_go) begin
          nxt_state = LATCH;
        end
      end
      LATCH: begin
        nxt_state = EXEC;
      end
      EXEC: begin
        sel_mem_in = is_mem_op(opcode);
        // Qualifiers drop during reset so a reset in EXEC never writes
        exec_en    = ~rst & (opcode != OP_LW);
        pc_load    = brnch & br_taken;
        pc_inc     = ~(brnch & br_taken);
        nxt_state  = (opcode == OP_LW) ? WB : FETCH;
      end
      WB: begin
        sel_mem_in = 1'b1;
        wb_en      = ~rst;
        nxt_state  = FETCH;
      end
      default: begin
        nxt_state = FETCH;
      end
    endcase
  end

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (br_target),
    .pc       (pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with an instruction-level reference model
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
`ifdef FETCH_SINGLE_STEP_EN
  logic       step;
`endif
  logic [7:0] mem_rdata;
  logic       brnch;
  logic       br_taken;
  logic [7:0] br_target;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [2:0] opcode;
  logic [4:0] imm;
  logic       sel_mem_in;
  logic       exec_en;
  logic       wb_en;
  logic [1:0] state;

  fetch_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
`ifdef FETCH_SINGLE_STEP_EN
    .step       (step),
`endif
    .mem_rdata  (mem_rdata),
    .brnch      (brnch),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .imm        (imm),
    .sel_mem_in (sel_mem_in),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_lw;
    logic [7:0] ir;
    logic [7:0] ev_pc;
    logic       sel;
    logic [7:0] next_pc;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem[256];
  logic [7:0] model_pc;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Synchronous memory: address muxed exactly as the sequencer requests
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem[sel_mem_in ? br_target : pc];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_br();
    brnch     = 1'($urandom_range(0, 1));
    br_taken  = 1'($urandom_range(0, 1));
    br_target = 8'($urandom);
  endtask

  // One instruction from the current FETCH cycle; pushes the model's expectation first
  task automatic run_instr(input logic b, input logic t, input logic [7:0] tgt);
    exp_t e;
    logic [7:0] instr;
    instr     = mem[model_pc];
    e.is_lw   = (instr[7:5] == 3'b111);
    e.ir      = instr;
    e.sel     = (instr[7:5] == 3'b110) || e.is_lw;
    e.next_pc = (b && t) ? tgt : model_pc + 8'd1;
    e.ev_pc   = e.is_lw ? e.next_pc : model_pc;
    e.cyc     = cyc + (e.is_lw ? 3 : 2);
    exp_q.push_back(e);
    model_pc = e.next_pc;
    run = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b1;
`endif
    rand_br();
    tick();
    run = 1'($urandom_range(0, 1));
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'($urandom_range(0, 1));
`endif
    rand_br();
    tick();
    run       = 1'($urandom_range(0, 1));
    brnch     = b;
    br_taken  = t;
    br_target = tgt;
    tick();
    if (e.is_lw) begin
      rand_br();
      tick();
    end
    run = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
`ifdef FETCH_SINGLE_STEP_EN
      run  = 1'($urandom_range(0, 1));
      step = 1'b0;
`else
      run = 1'b0;
`endif
      rand_br();
      tick();
    end
    run = 1'b0;
  endtask

  // Monitor: every write qualifier pulse must match the next queued expectation
  logic       pend_pc = 1'b0;
  logic [7:0] pend_next;
  logic       prev_sel = 1'b0;
  logic       prev_exec = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (pend_pc) begin
      check("next_pc", 32'(pc), 32'(pend_next));
      pend_pc = 1'b0;
    end
    if (exec_en || wb_en) begin
      check("excl", 32'(exec_en & wb_en), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(wb_en), 32'(e.is_lw));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_ir", 32'(ir), 32'(e.ir));
        check("event_pc", 32'(pc), 32'(e.ev_pc));
        check("event_sel", 32'(sel_mem_in), 32'(e.sel));
        if (e.is_lw) begin
          check("lw_exec_sel", 32'(prev_sel), 32'd1);
          check("lw_exec_en", 32'(prev_exec), 32'd0);
        end
        pend_next = e.next_pc;
        pend_pc   = 1'b1;
      end
    end
    prev_sel  = sel_mem_in;
    prev_exec = exec_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h45;
    mem[8'h01] = 8'h21;
    mem[8'h02] = 8'h61;
    mem[8'h03] = 8'hE0;
    mem[8'h04] = 8'hA0;
    mem[8'h20] = 8'hA0;
    mem[8'h21] = 8'hA0;
    mem[8'hFF] = 8'h80;
    mem[8'h50] = 8'hC3;
    rst = 1'b1;
    run = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b0;
`endif
    brnch = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_ir", 32'(ir), 32'h00);
    check("rst_state", 32'(state), 32'd0);
    check("rst_exec_en", 32'(exec_en), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_sel", 32'(sel_mem_in), 32'd0);
    model_pc = 8'h00;

    run_instr(1'b0, 1'b0, 8'h00);
    run_instr(1'b0, 1'b1, 8'h77);
    idle(3);
    run_instr(1'b1, 1'b0, 8'h99);
    run_instr(1'b0, 1'b0, 8'h00);
    run_instr(1'b1, 1'b1, 8'h20);
    idle(2);
    run_instr(1'b1, 1'b0, 8'h40);
    run_instr(1'b1, 1'b1, 8'hFF);
    run_instr(1'b0, 1'b0, 8'h00);
    idle(4);
    check("parked_state", 32'(state), 32'd0);
    check("wrap_pc", 32'(pc), 32'h00);
    run_instr(1'b1, 1'b1, 8'h50);

    // SW at 0x50 with reset arriving in its EXEC cycle
    run = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b1;
`endif
    rand_br();
    tick();
    run = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick();
    rst = 1'b1;
    rand_br();
    #1;
    check("rstx_state", 32'(state), 32'd2);
    check("rstx_ir", 32'(ir), 32'hC3);
    check("rstx_exec_en", 32'(exec_en), 32'd0);
    tick();
    rst = 1'b0;
    check("rstx_next_state", 32'(state), 32'd0);
    check("rstx_pc", 32'(pc), 32'h00);
    check("rstx_ir_clr", 32'(ir), 32'h00);
    model_pc = 8'h00;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 150; n++) begin
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_pc", 32'(pc), 32'(model_pc));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
